// File: rtl/fpga_io_pkg.sv
// Shared constants for the board-level LED output stage: display mode codes
// and the LED-count helper used to size the GPIO/LED buses.
package fpga_io_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'd0;
  localparam logic [1:0] MODE_STRETCH = 2'd1;
  localparam logic [1:0] MODE_PWM     = 2'd2;
  localparam logic [1:0] MODE_WALK    = 2'd3;

  function automatic int nled(input int num_ports, input int port_width);
    return num_ports * port_width;
  endfunction

endpackage

// File: rtl/led_stretch.sv
// One-bit pulse stretcher: keeps the output high for STRETCH_CYCLES extra
// cycles after the input falls; a new high input always reloads the counter.
module led_stretch import fpga_io_pkg::*; #(
  parameter int STRETCH_CYCLES = 1048576
) (
  input  logic clock,
  input  logic clr,
  input  logic din,
  output logic str
);

  localparam int CW = $clog2(STRETCH_CYCLES + 1);
  localparam logic [CW-1:0] LOAD = CW'(STRETCH_CYCLES);

  logic [CW-1:0] s_cnt_reg;

  always_ff @(posedge clock) begin
    if (clr) begin
      s_cnt_reg <= '0;
    end else if (din) begin
      s_cnt_reg <= LOAD;
    end else if (s_cnt_reg != '0) begin
      s_cnt_reg <= s_cnt_reg - CW'(1);
    end
  end

  assign str = din | (s_cnt_reg != '0);

endmodule

// File: rtl/fpga_led_driver.sv
// Board output stage: lock-qualified core reset plus a registered LED driver
// with direct, stretched, PWM-dimmed and walking self-test display modes.
module fpga_led_driver import fpga_io_pkg::*; #(
  parameter int NUM_PORTS      = 4,
  parameter int PORT_WIDTH     = 2,
  parameter int STRETCH_CYCLES = 1048576,
  parameter int PWM_BITS       = 4,
  parameter int STEP_CYCLES    = 8388608,
  parameter int RESET_HOLD     = 16,
  localparam int NLED          = nled(NUM_PORTS, PORT_WIDTH)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                locked,
  output logic                core_reset,
  input  logic [NLED-1:0]     gpio_in,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] pwm_duty,
  output logic [NLED-1:0]     leds
);

  localparam int HW = $clog2(RESET_HOLD + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(RESET_HOLD);
  localparam int SW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);
  localparam int IW = (NLED > 1) ? $clog2(NLED) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NLED - 1);

  logic [HW-1:0]       hold_cnt_reg;
  logic                int_rst;
  logic [NLED-1:0]     gpio_q_reg;
  logic [NLED-1:0]     str;
  logic [PWM_BITS-1:0] pwm_cnt_reg;
  logic                pwm_on;
  logic [SW-1:0]       step_cnt_reg;
  logic [IW-1:0]       walk_idx_reg;
  logic [NLED-1:0]     walk_pat;
  logic [NLED-1:0]     leds_next;
  logic [NLED-1:0]     leds_reg;

  // The core only leaves reset after locked has stayed high for RESET_HOLD cycles.
  always_ff @(posedge clock) begin
    if (reset || !locked) begin
      hold_cnt_reg <= '0;
    end else if (hold_cnt_reg != HOLD_MAX) begin
      hold_cnt_reg <= hold_cnt_reg + HW'(1);
    end
  end

  assign core_reset = (hold_cnt_reg != HOLD_MAX);
  assign int_rst    = reset | core_reset;

  always_ff @(posedge clock) begin
    if (int_rst) begin
      gpio_q_reg <= '0;
    end else begin
      gpio_q_reg <= gpio_in;
    end
  end

  generate
    for (genvar gi = 0; gi < NLED; gi++) begin : g_bit
      led_stretch #(
        .STRETCH_CYCLES(STRETCH_CYCLES)
      ) u_stretch (
        .clock(clock),
        .clr  (int_rst),
        .din  (gpio_q_reg[gi]),
        .str  (str[gi])
      );
      assign walk_pat[gi] = (walk_idx_reg == IW'(gi));
    end
  endgenerate

  always_ff @(posedge clock) begin
    if (int_rst) begin
      pwm_cnt_reg <= '0;
    end else begin
      pwm_cnt_reg <= pwm_cnt_reg + PWM_BITS'(1);
    end
  end

  assign pwm_on = (pwm_cnt_reg < pwm_duty);

  // Walk position only advances while the walk is on display, so it resumes where it left off.
  always_ff @(posedge clock) begin
    if (int_rst) begin
      step_cnt_reg <= '0;
      walk_idx_reg <= '0;
    end else if (mode == MODE_WALK) begin
      if (step_cnt_reg == STEP_MAX) begin
        step_cnt_reg <= '0;
        walk_idx_reg <= (walk_idx_reg == IDX_MAX) ? '0 : walk_idx_reg + IW'(1);
      end else begin
        step_cnt_reg <= step_cnt_reg + SW'(1);
      end
    end
  end

  always_comb begin
    leds_next = '0;
    case (mode)
      MODE_DIRECT:  leds_next = gpio_q_reg;
      MODE_STRETCH: leds_next = str;
      MODE_PWM:     leds_next = gpio_q_reg & {NLED{pwm_on}};
      MODE_WALK:    leds_next = walk_pat;
      default:      leds_next = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (int_rst) begin
      leds_reg <= '0;
    end else begin
      leds_reg <= leds_next;
    end
  end

  assign leds = leds_reg;

endmodule

// File: tb/tb_fpga_led_driver.sv
// Directed bench for fpga_led_driver with NLED=8, RESET_HOLD=4,
// STRETCH_CYCLES=3, PWM_BITS=4 and STEP_CYCLES=2.
module tb_fpga_led_driver;

  logic       clock;
  logic       reset;
  logic       locked;
  logic       core_reset;
  logic [7:0] gpio_in;
  logic [1:0] mode;
  logic [3:0] pwm_duty;
  logic [7:0] leds;

  int checks_total;
  int checks_passed;

  fpga_led_driver #(
    .NUM_PORTS     (4),
    .PORT_WIDTH    (2),
    .STRETCH_CYCLES(3),
    .PWM_BITS      (4),
    .STEP_CYCLES   (2),
    .RESET_HOLD    (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .locked    (locked),
    .core_reset(core_reset),
    .gpio_in   (gpio_in),
    .mode      (mode),
    .pwm_duty  (pwm_duty),
    .leds      (leds)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic exp_cr;
    reset = 1'b1; locked = 1'b0; mode = 2'd0; gpio_in = 8'hFF; pwm_duty = 4'd0;
    repeat (3) tick();
    checks_total++;
    if (core_reset !== 1'b1) $display("FAIL reset_core_reset: got %b, want 1", core_reset);
    else checks_passed++;
    checks_total++;
    if (leds !== 8'h00) $display("FAIL reset_leds: got %h, want 00", leds);
    else checks_passed++;
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      checks_total++;
      if (core_reset !== 1'b1) $display("FAIL unlocked_core_reset[%0d]: got %b, want 1", k, core_reset);
      else checks_passed++;
    end
    locked = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_cr = (k < 4);
      checks_total++;
      if (core_reset !== exp_cr) $display("FAIL lock_release[%0d]: got %b, want %b", k, core_reset, exp_cr);
      else checks_passed++;
    end
    repeat (3) tick();
    checks_total++;
    if (leds !== 8'hFF) $display("FAIL post_release_leds: got %h, want ff", leds);
    else checks_passed++;
    locked = 1'b0;
    tick();
    checks_total++;
    if (core_reset !== 1'b1) $display("FAIL lock_drop_core_reset: got %b, want 1", core_reset);
    else checks_passed++;
    checks_total++;
    if (leds !== 8'hFF) $display("FAIL lock_drop_leds_same_cycle: got %h, want ff", leds);
    else checks_passed++;
    locked = 1'b1;
    tick();
    checks_total++;
    if (leds !== 8'h00) $display("FAIL lock_drop_leds_cleared: got %h, want 00", leds);
    else checks_passed++;
    checks_total++;
    if (core_reset !== 1'b1) $display("FAIL relock_core_reset[1]: got %b, want 1", core_reset);
    else checks_passed++;
    for (int k = 2; k <= 4; k++) begin
      tick();
      exp_cr = (k < 4);
      checks_total++;
      if (core_reset !== exp_cr) $display("FAIL relock_core_reset[%0d]: got %b, want %b", k, core_reset, exp_cr);
      else checks_passed++;
    end
  endtask

  task automatic test_walk();
    logic [7:0] exp;
    mode = 2'd3;
    for (int k = 0; k <= 16; k++) begin
      tick();
      gpio_in = 8'($urandom);
      exp = 8'h01 << ((k / 2) % 8);
      checks_total++;
      if (leds !== exp) $display("FAIL walk[%0d]: got %h, want %h", k, leds, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_direct();
    mode = 2'd0; gpio_in = 8'h00;
    repeat (3) tick();
    gpio_in = 8'hA5;
    tick();
    checks_total++;
    if (leds !== 8'h00) $display("FAIL direct_latency_t1: got %h, want 00", leds);
    else checks_passed++;
    tick();
    checks_total++;
    if (leds !== 8'hA5) $display("FAIL direct_a5_t2: got %h, want a5", leds);
    else checks_passed++;
    repeat (3) tick();
    gpio_in = 8'h00;
    tick();
    checks_total++;
    if (leds !== 8'hA5) $display("FAIL direct_hold_t6: got %h, want a5", leds);
    else checks_passed++;
    tick();
    checks_total++;
    if (leds !== 8'h00) $display("FAIL direct_clear_t7: got %h, want 00", leds);
    else checks_passed++;
  endtask

  task automatic test_stretch();
    logic [7:0] exp;
    mode = 2'd1; gpio_in = 8'h00;
    repeat (5) tick();
    checks_total++;
    if (leds !== 8'h00) $display("FAIL stretch_idle: got %h, want 00", leds);
    else checks_passed++;
    // Single pulse: high after ticks 2..5.
    for (int k = 1; k <= 7; k++) begin
      gpio_in = (k == 1) ? 8'h08 : 8'h00;
      tick();
      exp = (k >= 2 && k <= 5) ? 8'h08 : 8'h00;
      checks_total++;
      if (leds !== exp) $display("FAIL stretch_pulse[%0d]: got %h, want %h", k, leds, exp);
      else checks_passed++;
    end
    repeat (3) tick();
    // Second pulse three cycles later lands in the tail and extends to tick 8.
    for (int k = 1; k <= 11; k++) begin
      gpio_in = (k == 1 || k == 4) ? 8'h08 : 8'h00;
      tick();
      exp = (k >= 2 && k <= 8) ? 8'h08 : 8'h00;
      checks_total++;
      if (leds !== exp) $display("FAIL stretch_reload[%0d]: got %h, want %h", k, leds, exp);
      else checks_passed++;
    end
  endtask

  task automatic test_pwm();
    int duties[3];
    int on_count;
    duties[0] = 4; duties[1] = 0; duties[2] = 15;
    mode = 2'd2; gpio_in = 8'hFF;
    for (int d = 0; d < 3; d++) begin
      pwm_duty = 4'(duties[d]);
      repeat (2) tick();
      on_count = 0;
      for (int k = 0; k < 16; k++) begin
        tick();
        if (leds === 8'hFF) on_count++;
        else begin
          checks_total++;
          if (leds !== 8'h00) $display("FAIL pwm_level[duty %0d]: got %h, want ff or 00", duties[d], leds);
          else checks_passed++;
        end
      end
      checks_total++;
      if (on_count != duties[d])
        $display("FAIL pwm_on_count[duty %0d]: got %0d, want %0d", duties[d], on_count, duties[d]);
      else checks_passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic exp_cr;
    mode = 2'd1; gpio_in = 8'h00; pwm_duty = 4'd0;
    repeat (5) tick();
    gpio_in = 8'h81;
    tick();
    gpio_in = 8'h00;
    tick();
    checks_total++;
    if (leds !== 8'h81) $display("FAIL mid_stretch_active: got %h, want 81", leds);
    else checks_passed++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks_total++;
    if (leds !== 8'h00) $display("FAIL mid_reset_leds: got %h, want 00", leds);
    else checks_passed++;
    checks_total++;
    if (core_reset !== 1'b1) $display("FAIL mid_reset_core_reset: got %b, want 1", core_reset);
    else checks_passed++;
    for (int k = 1; k <= 4; k++) begin
      tick();
      exp_cr = (k < 4);
      checks_total++;
      if (core_reset !== exp_cr) $display("FAIL mid_resequence[%0d]: got %b, want %b", k, core_reset, exp_cr);
      else checks_passed++;
      checks_total++;
      if (leds !== 8'h00) $display("FAIL mid_resequence_leds[%0d]: got %h, want 00", k, leds);
      else checks_passed++;
    end
    repeat (3) tick();
    checks_total++;
    if (leds !== 8'h00) $display("FAIL mid_counters_cleared: got %h, want 00", leds);
    else checks_passed++;
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    test_reset();
    test_walk();
    test_direct();
    test_stretch();
    test_pwm();
    test_reset_mid();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
